// File: rtl/led_counter_pkg.sv
// +----------------------------------------------------------------------+
// | led_counter_pkg: display mode and bounce direction encodings         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package led_counter_pkg;

  localparam logic [1:0] MODE_UP     = 2'd0;
  localparam logic [1:0] MODE_DOWN   = 2'd1;
  localparam logic [1:0] MODE_GRAY   = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

`default_nettype wire

// File: rtl/led_pattern_counter_tick_divider.sv
// +----------------------------------------------------------------------+
// | tick_divider: run-gated prescaler, one tick per DIV running cycles   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tick_divider #(
  parameter int DIV = 65536
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int PRE_W = (DIV <= 1) ? 1 : $clog2(DIV);
  localparam logic [PRE_W-1:0] c_TERM = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] r_pre;
  logic             w_at_term;

  // With DIV=1 the terminal count is 0, so every running cycle ticks.
  assign w_at_term = (r_pre == c_TERM);
  assign tick      = run & w_at_term;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre <= '0;
    end else if (run) begin
      if (w_at_term) r_pre <= '0;
      else           r_pre <= r_pre + PRE_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_pattern_counter.sv
// +----------------------------------------------------------------------+
// | led_pattern_counter: prescaled LED pattern generator (up/down/gray/  |
// | bounce) with step, parallel load and wrap pulse.  Rev 1.0            |
// +----------------------------------------------------------------------+
`default_nettype none

module led_pattern_counter
  import led_counter_pkg::*;
#(
  parameter int LED_W = 8,
  parameter int DIV   = 65536
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [LED_W-1:0] load_val,
  output logic [LED_W-1:0] led,
  output logic             wrap
);

  localparam int POS_W = $clog2(LED_W);
  localparam logic [POS_W-1:0] c_POS_MAX  = POS_W'(LED_W - 1);
  localparam logic [POS_W-1:0] c_POS_TURN = POS_W'(LED_W - 2);

  logic             w_tick;
  logic             w_adv;
  logic [LED_W-1:0] r_cnt,  w_cnt_nx;
  logic [POS_W-1:0] r_pos,  w_pos_nx;
  dir_e             r_dir,  w_dir_nx;
  logic [LED_W-1:0] w_led_nx;
  logic             w_wrap_nx;

  tick_divider #(.DIV(DIV)) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tick  (w_tick)
  );

  assign w_adv = w_tick | step;

  always_comb begin
    w_cnt_nx  = r_cnt;
    w_pos_nx  = r_pos;
    w_dir_nx  = r_dir;
    w_wrap_nx = 1'b0;
    if (load) begin
      w_cnt_nx = load_val;
      w_pos_nx = '0;
      w_dir_nx = DIR_UP;
    end else if (w_adv) begin
      case (mode)
        MODE_UP, MODE_GRAY: begin
          w_cnt_nx  = r_cnt + LED_W'(1);
          w_wrap_nx = &r_cnt;
        end
        MODE_DOWN: begin
          w_cnt_nx  = r_cnt - LED_W'(1);
          w_wrap_nx = ~|r_cnt;
        end
        default: begin
          // Bounce reverses at either end, stepping straight to the neighbour.
          if (r_dir == DIR_UP) begin
            if (r_pos == c_POS_MAX) begin
              w_dir_nx  = DIR_DOWN;
              w_pos_nx  = c_POS_TURN;
              w_wrap_nx = 1'b1;
            end else begin
              w_pos_nx = r_pos + POS_W'(1);
            end
          end else begin
            if (r_pos == '0) begin
              w_dir_nx  = DIR_UP;
              w_pos_nx  = POS_W'(1);
              w_wrap_nx = 1'b1;
            end else begin
              w_pos_nx = r_pos - POS_W'(1);
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    w_led_nx = w_cnt_nx;
    case (mode)
      MODE_GRAY:   w_led_nx = w_cnt_nx ^ (w_cnt_nx >> 1);
      MODE_BOUNCE: w_led_nx = LED_W'(1) << w_pos_nx;
      default:     w_led_nx = w_cnt_nx;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_pos <= '0;
      r_dir <= DIR_UP;
      led   <= '0;
      wrap  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nx;
      r_pos <= w_pos_nx;
      r_dir <= w_dir_nx;
      led   <= w_led_nx;
      wrap  <= w_wrap_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_counter.sv
// +----------------------------------------------------------------------+
// | tb_led_pattern_counter: directed self-checking bench, LED_W=4 DIV=4  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_led_pattern_counter;

  localparam int LED_W = 4;
  localparam int DIV   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             run;
  logic             step;
  logic [1:0]       mode;
  logic             load;
  logic [LED_W-1:0] load_val;
  logic [LED_W-1:0] led;
  logic             wrap;

  int n_tests = 0;
  int n_fail  = 0;

  led_pattern_counter #(.LED_W(LED_W), .DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .step     (step),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .led      (led),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs changed 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_step();
    step = 1'b1;
    cyc();
    step = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  logic [3:0] gray_exp [4];
  logic [3:0] bnc_led  [7];
  logic       bnc_wrap [7];

  initial begin
    gray_exp = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};
    bnc_led  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    bnc_wrap = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; run = 1'b0; step = 1'b0; mode = 2'd0;
    load = 1'b0; load_val = '0;
    cyc(); cyc();
    check("reset_led",  {28'd0, led}, 32'd0);
    check("reset_wrap", {31'd0, wrap}, 32'd0);

    // Up count from reset: one advance every 4 running cycles, wrap on 15 -> 0.
    reset = 1'b0; run = 1'b1; mode = 2'd0;
    for (int a = 1; a <= 16; a++) begin
      for (int c = 0; c < 3; c++) begin
        cyc();
        check("up_hold_led",  {28'd0, led}, 32'((a - 1) % 16));
        check("up_hold_wrap", {31'd0, wrap}, 32'd0);
      end
      cyc();
      check("up_adv_led",  {28'd0, led}, 32'(a % 16));
      check("up_adv_wrap", {31'd0, wrap}, (a == 16) ? 32'd1 : 32'd0);
    end
    cyc();
    check("up_wrap_once", {31'd0, wrap}, 32'd0);
    check("up_after_led", {28'd0, led}, 32'd0);

    // Down mode, steps only with run low.
    run = 1'b0;
    do_reset();
    mode = 2'd1;
    cyc();
    check("down_idle_led", {28'd0, led}, 32'd0);
    do_step();
    check("down_s1_led",  {28'd0, led}, 32'hF);
    check("down_s1_wrap", {31'd0, wrap}, 32'd1);
    do_step();
    check("down_s2_led",  {28'd0, led}, 32'hE);
    check("down_s2_wrap", {31'd0, wrap}, 32'd0);
    // Prescaler must still be at 0: exactly 4 running cycles to the next advance.
    run = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      check("down_pre_hold", {28'd0, led}, 32'hE);
    end
    cyc();
    check("down_pre_adv", {28'd0, led}, 32'hD);
    run = 1'b0;

    // Gray mode.
    do_reset();
    mode = 2'd2;
    cyc();
    check("gray_0", {28'd0, led}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      do_step();
      check("gray_step", {28'd0, led}, {28'd0, gray_exp[i]});
    end

    // Bounce mode.
    do_reset();
    mode = 2'd3;
    cyc();
    check("bnc_start", {28'd0, led}, 32'b0001);
    for (int i = 0; i < 7; i++) begin
      do_step();
      check("bnc_led",  {28'd0, led}, {28'd0, bnc_led[i]});
      check("bnc_wrap", {31'd0, wrap}, {31'd0, bnc_wrap[i]});
    end
    // Mode change alone only reformats: cnt is still 0, pos still 1.
    mode = 2'd0;
    cyc();
    check("modechg_up",  {28'd0, led}, 32'd0);
    mode = 2'd3;
    cyc();
    check("modechg_bnc", {28'd0, led}, 32'b0010);

    // Load beats a coincident step.
    do_reset();
    mode = 2'd0;
    cyc();
    load = 1'b1; load_val = 4'b1010; step = 1'b1;
    cyc();
    load = 1'b0; step = 1'b0;
    check("load_led",  {28'd0, led}, 32'b1010);
    check("load_wrap", {31'd0, wrap}, 32'd0);
    do_step();
    check("load_next", {28'd0, led}, 32'b1011);

    // Reset mid-count with run high.
    do_reset();
    run = 1'b1;
    for (int c = 0; c < 6; c++) cyc();
    check("mid_pre_led", {28'd0, led}, 32'd1);
    reset = 1'b1;
    cyc();
    check("mid_rst_led",  {28'd0, led}, 32'd0);
    check("mid_rst_wrap", {31'd0, wrap}, 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      check("mid_hold_led", {28'd0, led}, 32'd0);
    end
    cyc();
    check("mid_adv_led",  {28'd0, led}, 32'd1);
    check("mid_adv_wrap", {31'd0, wrap}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
